fifo_sync_wc: RTL

FIFO_SYNC_WC -- requirements
Module: fifo_sync_wc

---
 rtl/fifo_sync_wc.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fifo_sync_wc.sv
// Synchronous byte-granular FIFO with independent write and read word widths.
// Bytes are stored little-endian in a circular byte array of SIZE entries.
// Every status output is registered and is computed from the fill level the
// FIFO will hold after the current edge. As a result, each status output
// always matches the registered byte count.
module fifo_sync_wc #(
  parameter int DW_W     = 64,
  parameter int DW_R     = 32,
  parameter int SIZE     = 2048,
  parameter int AF_BYTES = 16,
  parameter int AE_BYTES = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   w_req,
  input  logic [DW_W-1:0]                        data_i,
  output logic                                   full,
  output logic                                   almost_full,
  input  logic                                   r_req,
  output logic [DW_R-1:0]                        data_o,
  output logic                                   empty,
  output logic                                   almost_empty,
  output logic [$clog2(SIZE/(DW_W/8)+1)-1:0]     w_cnt,
  output logic [$clog2(SIZE/(DW_R/8)+1)-1:0]     r_cnt,
  output logic                                   overflow,
  output logic                                   underflow
);

  localparam int WB     = DW_W / 8;
  localparam int RB     = DW_R / 8;
  localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int UW     = $clog2(SIZE + 1);
  localparam int WCNT_W = $clog2(SIZE / WB + 1);
  localparam int RCNT_W = $clog2(SIZE / RB + 1);

  logic [7:0]        mem [SIZE];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [UW-1:0]     used;

  logic              wr_en;
  logic              rd_en;
  int                used_n;
  logic              full_n;
  logic              empty_n;
  logic              af_n;
  logic              ae_n;
  logic [WCNT_W-1:0] w_cnt_n;
  logic [RCNT_W-1:0] r_cnt_n;
  logic              ovf_n;
  logic              udf_n;
  logic [DW_R-1:0]   rd_word;

  // Accept decisions, next fill level and the status it implies.
  // A flush overrides both requests. Errors are evaluated on the pre-edge flags.
  always_comb begin
    wr_en  = w_req && !full && !flush;
    rd_en  = r_req && !empty && !flush;
    used_n = int'(used);
    if (flush) begin
      used_n = 0;
    end else begin
      if (wr_en) used_n = used_n + WB;
      if (rd_en) used_n = used_n - RB;
    end
    full_n  = (SIZE - used_n) < WB;
    empty_n = used_n < RB;
    af_n    = used_n >= (SIZE - AF_BYTES);
    ae_n    = used_n <= AE_BYTES;
    w_cnt_n = WCNT_W'((SIZE - used_n) / WB);
    r_cnt_n = RCNT_W'(used_n / RB);
    ovf_n   = flush ? 1'b0 : (overflow  || (w_req && full));
    udf_n   = flush ? 1'b0 : (underflow || (r_req && empty));
  end

  // Gather the oldest RB bytes. Pointer arithmetic wraps naturally because SIZE is a power of two.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RB; i++) begin
      rd_word[8*i +: 8] = mem[AW'(int'(rptr) + i)];
    end
  end

  // Byte storage: write the whole input word, lowest byte at the write pointer. The array is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WB; i++) begin
        mem[AW'(int'(wptr) + i)] <= data_i[8*i +: 8];
      end
    end
  end

  // Pointers, fill level, registered status, read data and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      used         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      w_cnt        <= WCNT_W'(SIZE / WB);
      r_cnt        <= '0;
      data_o       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_en) wptr <= AW'(int'(wptr) + WB);
        if (rd_en) rptr <= AW'(int'(rptr) + RB);
      end
      if (rd_en) data_o <= rd_word;
      used         <= UW'(used_n);
      full         <= full_n;
      empty        <= empty_n;
      almost_full  <= af_n;
      almost_empty <= ae_n;
      w_cnt        <= w_cnt_n;
      r_cnt        <= r_cnt_n;
      overflow     <= ovf_n;
      underflow    <= udf_n;
    end
  end

endmodule
